mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single unified instruction/data memory between two requesters:
//   - port 0: the multi-cycle CPU (its fetch/load/store accesses).
//   - port 1: the debug/program loader.
// Runs one transaction at a time with round-robin arbitration, an optional debug lock,
// and a fixed-latency memory read pipeline. Sits between the CPU memory mux and the RAM.
// PARAMETERS
// ADDR_W   16  address width
// DATA_W   16  data width
// MEM_LAT  1   cycles from mem_en to valid mem_rdata; legal range >=1
// PORTS
// clk         in   1          clock; all state changes on the rising edge
// rst_n       in   1          asynchronous, active-low reset
// req_valid   in   2          per-port request; held until req_ready seen
// req_we      in   2          per-port: 1=write, 0=read
// req_addr    in   2*ADDR_W   port p occupies bits [p*ADDR_W +: ADDR_W]
// req_wdata   in   2*DATA_W   port p occupies bits [p*DATA_W +: DATA_W]
// req_ready   out  2          one-hot accept strobe (1 cycle)
// rsp_valid   out  2          one-hot completion strobe (1 cycle); asserted for reads and writes
// rsp_rdata   out  DATA_W     read data; valid with rsp_valid
// dbg_lock    in   1          1: port 1 has strict priority and port 0 is never granted
// mem_en      out  1          memory access strobe (1 cycle)
// mem_we      out  1          memory write enable (qualified by mem_en)
// mem_addr    out  ADDR_W     memory address
// mem_wdata   out  DATA_W     memory write data
// mem_rdata   in   DATA_W     memory read data
// busy        out  1          high in every state except IDLE
// BEHAVIOUR
// - Reset: every output is 0 (req_ready is forced to 0 while rst_n=0), state=IDLE, rr_last=1.
//   Asserting rst_n mid-transaction aborts it: mem_en drops at once, no rsp_valid is issued.
// - FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
//   - IDLE: if any req_valid, pick winner w. In that same cycle req_ready[w]=1 and
//     we/addr/wdata/w are latched; next state ACCESS. Otherwise stay in IDLE.
//   - ACCESS: mem_en=1; mem_we/addr/wdata come from the latched values; load cnt=MEM_LAT-1.
//     Next state is WAIT if MEM_LAT>1, else RESP.
//   - WAIT: decrement cnt; go to RESP when cnt reaches 1.
//     Counter width is $clog2(MEM_LAT+1); it never wraps.
//   - RESP: capture mem_rdata into rsp_rdata (a write captures 0); rsp_valid[w]=1; next state IDLE.
// - Latency: accept at cycle T -> mem_en at T+1 -> rsp_valid at T+1+MEM_LAT.
//   The earliest next accept is at T+2+MEM_LAT (one idle turnaround cycle).
// - Arbitration, evaluated only in IDLE:
//   - dbg_lock=1: grant port 1 if valid, otherwise grant nothing.
//   - Both ports valid and unlocked: grant port != rr_last. rr_last updates on every accept.
//   - Only one port valid: grant it, regardless of rr_last.
// - dbg_lock changing mid-transaction does not affect the transaction already in flight.
// - req_* inputs are sampled only in the accept cycle; later changes are ignored.
//   If a requester drops req_valid before req_ready, that is legal; the request is simply not taken.
// - req_ready and rsp_valid are never both high on the same port in one cycle,
//   and at most one port has any strobe active in a given cycle.
// - mem_en is high exactly once per accepted request.
// STRUCTURE
// - Package mem_arb_pkg holds:
//   - state encoding localparams ST_IDLE/ST_ACCESS/ST_WAIT/ST_RESP (2-bit);
//   - port id constants PORT_CPU=0 and PORT_DBG=1.
// - Sub-module rr_arbiter2: purely combinational winner select.
//   Inputs: valid[1:0], lock, last. Outputs: gnt one-hot, gnt_id.
//   It is instantiated once. The FSM, counter, latches and rr_last register stay in mem_port_arbiter.
// TESTING
// 1. Port 0 read addr 0x0010, MEM_LAT=1, RAM[0x10]=0xBEEF:
//    req_ready[0] at T, mem_en at T+1, rsp_valid[0] with rdata 0xBEEF at T+2.
// 2. Both ports write at the same time (p0 0x20<=0x1111, p1 0x21<=0x2222):
//    p0 is granted first (rr_last=1 after reset), then p1; RAM holds both values.
// 3. dbg_lock=1 with both ports valid for 3 back-to-back p1 reads:
//    req_ready[0] never asserts; the p0 grant follows the first IDLE after dbg_lock drops.
// 4. MEM_LAT=3, port 1 read 0x0004:
//    rsp_valid[1] exactly 4 cycles after req_ready[1]; busy high for 4 cycles.
// 5. rst_n pulled low in WAIT (MEM_LAT=3):
//    all outputs are 0 immediately; no rsp_valid after release;
//    the next request is served from IDLE with p0 preferred.
// 6. Port 0 drops req_valid before grant while port 1 holds:
//    port 1 is granted and mem_en fires once.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: state encoding and port ids.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ACCESS = ST_ACCESS,
      S_WAIT   = ST_WAIT,
      S_RESP   = ST_RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port winner select: debug lock gives port 1 strict priority, otherwise
// a tie goes to the port that did not win last time.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       lock,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   // Pick at most one winner from the currently valid requests
   always_comb begin
      gnt    = 2'b00;
      gnt_id = PORT_CPU;
      if (lock) begin
         if (valid[PORT_DBG]) begin
            gnt    = 2'b10;
            gnt_id = PORT_DBG;
         end
      end else if (valid == 2'b11) begin
         gnt_id = ~last;
         gnt    = last ? 2'b01 : 2'b10;
      end else if (valid[PORT_DBG]) begin
         gnt    = 2'b10;
         gnt_id = PORT_DBG;
      end else if (valid[PORT_CPU]) begin
         gnt    = 2'b01;
         gnt_id = PORT_CPU;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the CPU (port 0) and the debug loader
// (port 1). One transaction at a time: accept, access, wait out the read
// latency, respond, then one idle turnaround cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   input  logic                  dbg_lock,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    cnt;
   logic                rr_last;
   logic                we_lat;
   logic [ADDR_W-1:0]   addr_lat;
   logic [DATA_W-1:0]   wdata_lat;
   logic                port_lat;
   logic [DATA_W-1:0]   rdata_hold;
   logic [1:0]          gnt;
   logic                gnt_id;
   logic                accept;

   rr_arbiter2 u_arb (
      .valid  (req_valid),
      .lock   (dbg_lock),
      .last   (rr_last),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign accept = (state == S_IDLE) && (gnt != 2'b00);

   // Next-state logic for the single-transaction sequencer
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (accept) state_next = S_ACCESS;
         S_ACCESS: state_next = (MEM_LAT > 1) ? S_WAIT : S_RESP;
         S_WAIT:   if (cnt == CNT_W'(1)) state_next = S_RESP;
         S_RESP:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // State register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Latency counter: loaded on the access, counts down to 1 in WAIT, never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == S_ACCESS) begin
         cnt <= CNT_W'(MEM_LAT - 1);
      end else if (state == S_WAIT && cnt != CNT_W'(1)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Request capture and round-robin history, updated only on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last   <= PORT_DBG;
         we_lat    <= 1'b0;
         addr_lat  <= '0;
         wdata_lat <= '0;
         port_lat  <= PORT_CPU;
      end else if (accept) begin
         rr_last   <= gnt_id;
         we_lat    <= req_we[gnt_id];
         addr_lat  <= req_addr[gnt_id*ADDR_W +: ADDR_W];
         wdata_lat <= req_wdata[gnt_id*DATA_W +: DATA_W];
         port_lat  <= gnt_id;
      end
   end

   // Hold the last response data after the completion strobe ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                rdata_hold <= '0;
      else if (state == S_RESP)  rdata_hold <= we_lat ? '0 : mem_rdata;
   end

   // Outputs: strobes decoded from state; ready gated so reset forces it low
   always_comb begin
      req_ready = (accept && rst_n) ? gnt : 2'b00;
      rsp_valid = 2'b00;
      rsp_rdata = rdata_hold;
      if (state == S_RESP) begin
         rsp_valid = port_lat ? 2'b10 : 2'b01;
         rsp_rdata = we_lat ? '0 : mem_rdata;
      end
      mem_en    = (state == S_ACCESS);
      mem_we    = we_lat;
      mem_addr  = addr_lat;
      mem_wdata = wdata_lat;
      busy      = (state != S_IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (read latency 1 and 3),
// each with its own RAM model, driver, transaction-level reference and monitor.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   typedef struct {
      int           port;
      logic [DW-1:0] rdata;
      int           due;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests    = 0;
   int fails    = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference arbitration rule: -1 means nobody is granted
   function automatic int pick(input logic [1:0] v, input logic lock, input logic last);
      if (lock)          return v[1] ? 1 : -1;
      if (v == 2'b11)    return (last == 1'b1) ? 0 : 1;
      if (v[0])          return 0;
      if (v[1])          return 1;
      return -1;
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_inst
         localparam int LAT = (gi == 0) ? 1 : 3;

         logic              rst_n;
         logic [1:0]        req_valid, req_we, req_ready, rsp_valid;
         logic [2*AW-1:0]   req_addr;
         logic [2*DW-1:0]   req_wdata;
         logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
         logic              dbg_lock, mem_en, mem_we, busy;
         logic [AW-1:0]     mem_addr;

         mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .req_ready (req_ready),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .dbg_lock  (dbg_lock),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .busy      (busy)
         );

         // Memory with LAT-cycle read pipeline
         logic [DW-1:0] ram  [0:255] = '{default: '0};
         logic [DW-1:0] pipe [0:LAT-1] = '{default: '0};
         always @(posedge clk) begin
            if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            if (mem_en) pipe[0] <= ram[mem_addr[7:0]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
         end
         assign mem_rdata = pipe[LAT-1];

         // Reference model state
         int            cyc      = 0;
         int            next_ok  = 0;
         int            last_acc = -100;
         logic          rr_m     = 1'b1;
         logic [DW-1:0] mram [0:255] = '{default: '0};
         rsp_t          sb [$];
         int            accepts  = 0;
         int            men_cnt  = 0;
         int            stray    = 0;
         rsp_t          mr;

         logic [1:0]    pv = 2'b00;
         logic [1:0]    pwe = 2'b00;
         logic [AW-1:0] pa [2];
         logic [DW-1:0] pd [2];
         logic          plock = 1'b0;

         always @(posedge clk) cyc <= cyc + 1;

         // One cycle of stimulus: drive pending requests, predict and check the grant
         task automatic step();
            int   w;
            rsp_t r;
            @(posedge clk);
            #1;
            req_valid = pv;
            req_we    = pwe;
            req_addr  = {pa[1], pa[0]};
            req_wdata = {pd[1], pd[0]};
            dbg_lock  = plock;
            @(negedge clk);
            w = -1;
            if (rst_n && cyc >= next_ok) w = pick(pv, plock, rr_m);
            check($sformatf("ready_i%0d", gi), 64'(req_ready), (w < 0) ? 64'd0 : 64'(1 << w));
            if (w >= 0) begin
               accepts++;
               last_acc = cyc;
               next_ok  = cyc + 2 + LAT;
               rr_m     = w[0];
               r.port   = w;
               r.rdata  = pwe[w] ? '0 : mram[pa[w][7:0]];
               r.due    = cyc + 1 + LAT;
               if (pwe[w]) mram[pa[w][7:0]] = pd[w];
               sb.push_back(r);
               pv[w] = 1'b0;
            end
         endtask

         task automatic drain();
            for (int k = 0; k < 60 && pv != 2'b00; k++) step();
            if (pv != 2'b00) check($sformatf("drain_i%0d", gi), 64'(pv), 64'd0);
            repeat (LAT + 3) step();
         endtask

         task automatic set_req(input int p, input logic we, input int addr, input logic [DW-1:0] d);
            pv[p]  = 1'b1;
            pwe[p] = we;
            pa[p]  = AW'(addr);
            pd[p]  = d;
         endtask

         // Monitor: pops the scoreboard on every completion, checks busy/strobes/mem_en
         always @(negedge clk) begin
            if (rst_n === 1'b1) begin
               check($sformatf("busy_i%0d", gi), 64'(busy), 64'((cyc > last_acc) && (cyc < next_ok)));
               check($sformatf("onehot_i%0d", gi), 64'($countones({req_ready, rsp_valid}) > 1), 64'd0);
               if (mem_en) begin
                  men_cnt++;
                  check($sformatf("mem_en_cyc_i%0d", gi), 64'(cyc), 64'(last_acc + 1));
               end
               if (rsp_valid != 2'b00) begin
                  if (sb.size() == 0) begin
                     stray++;
                     check($sformatf("stray_rsp_i%0d", gi), 64'(rsp_valid), 64'd0);
                  end else begin
                     mr = sb.pop_front();
                     $display("[TB] inst%0d rsp port%0d rdata %h cyc %0d", gi, mr.port, rsp_rdata, cyc);
                     check($sformatf("rsp_port_i%0d", gi), 64'(rsp_valid), 64'(1 << mr.port));
                     check($sformatf("rsp_rdata_i%0d", gi), 64'(rsp_rdata), 64'(mr.rdata));
                     check($sformatf("rsp_cyc_i%0d", gi), 64'(cyc), 64'(mr.due));
                  end
               end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                  mr = sb.pop_front();
                  check($sformatf("rsp_missing_i%0d", gi), 64'(cyc), 64'(mr.due - 1));
               end
            end
         end

         // Driver: directed scenarios, then randomized traffic
         initial begin
            rst_n     = 1'b0;
            req_valid = 2'b11;
            req_we    = 2'b00;
            req_addr  = '0;
            req_wdata = '0;
            dbg_lock  = 1'b0;
            pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
            repeat (3) @(negedge clk);
            #1;
            check($sformatf("rst_outs_i%0d", gi),
                  64'({req_ready, rsp_valid, mem_en, mem_we, mem_addr, mem_wdata, rsp_rdata, busy}), 64'd0);
            req_valid = 2'b00;
            #1 rst_n = 1'b1;

            // Simultaneous writes: port 0 first after reset, then port 1
            set_req(0, 1'b1, 'h20, 16'h1111);
            set_req(1, 1'b1, 'h21, 16'h2222);
            drain();
            set_req(0, 1'b0, 'h20, '0);
            drain();
            set_req(1, 1'b0, 'h21, '0);
            drain();

            // Loader writes 0xBEEF, CPU reads it back
            set_req(1, 1'b1, 'h10, 16'hBEEF);
            drain();
            set_req(0, 1'b0, 'h10, '0);
            drain();

            // Debug lock: three port-1 reads while port 0 waits, then unlock
            plock = 1'b1;
            set_req(0, 1'b0, 'h20, '0);
            set_req(1, 1'b0, 'h04, '0);
            for (int k = 0; k < 3; k++) begin
               for (int j = 0; j < 20 && pv[1]; j++) step();
               set_req(1, 1'b0, k, '0);
            end
            plock = 1'b0;
            drain();

            // Reset in the middle of a read
            set_req(0, 1'b0, 'h21, '0);
            for (int j = 0; j < 20 && pv[0]; j++) step();
            @(posedge clk);
            #1 req_valid = 2'b11;
            repeat (LAT) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check($sformatf("abort_outs_i%0d", gi),
                  64'({req_ready, rsp_valid, mem_en, busy, rsp_rdata}), 64'd0);
            sb.delete();
            rr_m = 1'b1; next_ok = 0; last_acc = -100;
            req_valid = 2'b00;
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            set_req(0, 1'b0, 'h20, '0);
            set_req(1, 1'b0, 'h21, '0);
            drain();
            check($sformatf("no_rsp_after_rst_i%0d", gi), 64'(stray), 64'd0);

            // Port 0 withdraws while the arbiter is busy; port 1 is then served
            set_req(0, 1'b0, 'h04, '0);
            step();
            set_req(0, 1'b0, 'h05, '0);
            set_req(1, 1'b1, 'h06, 16'h6666);
            step();
            pv[0] = 1'b0;
            drain();

            // Randomized traffic
            for (int it = 0; it < 300; it++) begin
               for (int p = 0; p < 2; p++) begin
                  if (!pv[p] && ($urandom % 3 == 0))
                     set_req(p, 1'($urandom), int'($urandom_range(0, 31)), 16'($urandom));
                  else if (pv[p] && ($urandom % 16 == 0))
                     pv[p] = 1'b0;
               end
               if ($urandom % 20 == 0) plock = ~plock;
               step();
            end
            plock = 1'b0;
            drain();

            check($sformatf("mem_en_count_i%0d", gi), 64'(men_cnt), 64'(accepts));
            check($sformatf("sb_empty_i%0d", gi), 64'(sb.size()), 64'd0);
            done_cnt++;
         end
      end
   endgenerate

   initial begin
      wait (done_cnt == 2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
